// File: rtl/alu_pkg.sv
// alu_pkg: shift mode constants and shift sequencer state encoding shared across the ALU
package alu_pkg;
   localparam logic [1:0] SH_LOGIC = 2'b00;
   localparam logic [1:0] SH_ARITH = 2'b01;
   localparam logic [1:0] SH_ROT   = 2'b10;
   localparam logic [1:0] SH_FILL  = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-position shifter (logical, arithmetic, rotate, fill)
module shift_step
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] d,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             fill,
   output logic [WIDTH-1:0] q
);
   logic in_r, in_l;
   // arithmetic left shifts in zero, same as logical
   assign in_r = mode == SH_ARITH ? d[WIDTH-1] : mode == SH_ROT ? d[0] : mode == SH_FILL ? fill : 1'b0;
   assign in_l = mode == SH_ROT ? d[WIDTH-1] : mode == SH_FILL ? fill : 1'b0;
   assign q = dir ? {in_r, d[WIDTH-1:1]} : {d[WIDTH-2:0], in_l};
endmodule

// File: rtl/shift_seq.sv
// shift_seq: serial shifter, one bit position per clock, done pulse when the result is ready
module shift_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             fill,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y
);
   state_t           state, nxt;
   logic [AMT_W-1:0] cnt;
   logic             dir_q, fill_q;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] y_sh;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d   (y),
      .dir (dir_q),
      .mode(mode_q),
      .fill(fill_q),
      .q   (y_sh)
   );

   always_comb begin
      nxt   = state == S_IDLE  ? (start ? (amt == '0 ? S_DONE : S_SHIFT) : S_IDLE)
            : state == S_SHIFT ? (cnt == AMT_W'(1) ? S_DONE : S_SHIFT)
            : S_IDLE;
      ready = state == S_IDLE;
      busy  = state == S_SHIFT;
      done  = state == S_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         y      <= '0;
         cnt    <= '0;
         dir_q  <= 1'b0;
         mode_q <= SH_LOGIC;
         fill_q <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) begin
            y      <= a;
            cnt    <= amt;
            dir_q  <= dir;
            mode_q <= mode;
            fill_q <= fill;
         end else if (state == S_SHIFT) begin
            y   <= y_sh;
            cnt <= cnt - AMT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard-driven checks of shift_seq results, timing and reset behaviour
module tb_shift_seq;
   logic       clk = 0, rst_n = 0, start = 0, dir = 0, fill = 0;
   logic [1:0] mode = 0;
   logic [7:0] a = 0;
   logic [2:0] amt = 0;
   logic       ready, busy, done;
   logic [7:0] y;
   int         total = 0, passed = 0;
   logic [7:0] exp_q[$];

   shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mode(mode), .fill(fill),
      .a(a), .amt(amt), .ready(ready), .busy(busy), .done(done), .y(y)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // reference built from whole-word shift operators rather than stepwise shifting
   function automatic logic [7:0] model(input logic [7:0] v, input logic d, input logic [1:0] m,
                                        input logic f, input int n);
      logic signed [7:0] s;
      logic [7:0] r, hi, lo;
      hi = 8'hFF >> n;
      hi = ~hi;
      lo = 8'hFF << n;
      lo = ~lo;
      s  = v;
      s  = s >>> n;
      r  = d ? v >> n : v << n;
      if (m == 2'b01 && d) r = s;
      if (m == 2'b10) r = d ? (v >> n) | (v << (8 - n)) : (v << n) | (v >> (8 - n));
      if (m == 2'b11 && f) r = r | (d ? hi : lo);
      return r;
   endfunction

   task automatic launch(input logic [7:0] ai, input logic di, input logic [1:0] mi,
                         input logic fi, input logic [2:0] ami);
      @(negedge clk);
      a = ai; dir = di; mode = mi; fill = fi; amt = ami; start = 1;
      @(negedge clk);
      start = 0;
      a = $urandom; dir = $urandom; mode = $urandom; fill = $urandom; amt = $urandom;
   endtask

   task automatic wait_done(output int lat, output int bz, output logic [7:0] yd);
      lat = 1;
      bz  = 0;
      while (!done && lat < 20) begin
         bz += int'(busy);
         @(negedge clk);
         lat++;
      end
      yd = y;
   endtask

   task automatic test_reset;
      #12;
      total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++; if (y !== 8'h00) $display("FAIL reset_y: got %h want 00", y); else passed++;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_logic_left;
      int lat, bz; logic [7:0] yd, e;
      exp_q.push_back(8'h54);
      launch(8'hAA, 0, 2'b00, 0, 3'd1);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL logic_left_y: got %h want %h", yd, e); else passed++;
      total++; if (lat !== 2) $display("FAIL logic_left_latency: got %0d want 2", lat); else passed++;
   endtask

   task automatic test_arith_right;
      int lat, bz; logic [7:0] yd, e;
      exp_q.push_back(8'hF3);
      launch(8'hCD, 1, 2'b01, 0, 3'd2);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL arith_right_y: got %h want %h", yd, e); else passed++;
      total++; if (bz !== 2) $display("FAIL arith_right_busy_cycles: got %0d want 2", bz); else passed++;
   endtask

   task automatic test_rotate_left;
      int lat, bz; logic [7:0] yd, e;
      exp_q.push_back(8'h6E);
      launch(8'hCD, 0, 2'b10, 0, 3'd3);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL rotate_left_y: got %h want %h", yd, e); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL rotate_done_pulse: got %b want 0", done); else passed++;
      total++; if (ready !== 1'b1) $display("FAIL rotate_ready_after: got %b want 1", ready); else passed++;
      total++; if (y !== e) $display("FAIL rotate_y_hold: got %h want %h", y, e); else passed++;
   endtask

   task automatic test_fill_right;
      int lat, bz; logic [7:0] yd, e;
      exp_q.push_back(8'hF0);
      launch(8'h00, 1, 2'b11, 1, 3'd4);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL fill_right_y: got %h want %h", yd, e); else passed++;
      total++; if (lat !== 5) $display("FAIL fill_right_latency: got %0d want 5", lat); else passed++;
   endtask

   task automatic test_back_to_back;
      int lat, bz, dn; logic [7:0] yd, e;
      exp_q.push_back(8'h5A);
      launch(8'h5A, 0, 2'b10, 0, 3'd0);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL amt0_y: got %h want %h", yd, e); else passed++;
      total++; if (lat !== 1) $display("FAIL amt0_latency: got %0d want 1", lat); else passed++;
      exp_q.push_back(model(8'h81, 1, 2'b10, 0, 3));
      launch(8'h81, 1, 2'b10, 0, 3'd3);
      a = 8'hFF; dir = 0; mode = 2'b00; amt = 3'd0; start = 1;
      @(negedge clk);
      start = 0;
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL ignored_start_y: got %h want %h", yd, e); else passed++;
      total++; if (lat + 1 !== 4) $display("FAIL ignored_start_latency: got %0d want 4", lat + 1); else passed++;
      dn = 0;
      repeat (4) begin @(negedge clk); dn += int'(done); end
      total++; if (dn !== 0) $display("FAIL ignored_start_queued: got %0d extra done want 0", dn); else passed++;
      total++; if (y !== e) $display("FAIL ignored_start_hold: got %h want %h", y, e); else passed++;
   endtask

   task automatic test_reset_mid;
      int lat, bz, dn; logic [7:0] yd, e;
      launch(8'hFF, 0, 2'b00, 0, 3'd7);
      @(negedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      total++; if (y !== 8'h00) $display("FAIL midreset_y: got %h want 00", y); else passed++;
      total++; if (ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
      dn = 0;
      repeat (2) begin @(negedge clk); dn += int'(done); end
      rst_n = 1;
      repeat (8) begin @(negedge clk); dn += int'(done); end
      total++; if (dn !== 0) $display("FAIL midreset_done: got %0d pulses want 0", dn); else passed++;
      exp_q.push_back(model(8'hFF, 0, 2'b00, 0, 7));
      launch(8'hFF, 0, 2'b00, 0, 3'd7);
      wait_done(lat, bz, yd);
      e = exp_q.pop_front();
      total++; if (yd !== e) $display("FAIL postreset_y: got %h want %h", yd, e); else passed++;
      total++; if (lat !== 8) $display("FAIL postreset_latency: got %0d want 8", lat); else passed++;
   endtask

   task automatic test_random;
      int lat, bz; logic [7:0] yd, e, ra; logic rd, rf; logic [1:0] rm; logic [2:0] rn;
      for (int i = 0; i < 24; i++) begin
         ra = $urandom; rd = $urandom; rm = $urandom; rf = $urandom; rn = $urandom;
         exp_q.push_back(model(ra, rd, rm, rf, int'(rn)));
         launch(ra, rd, rm, rf, rn);
         wait_done(lat, bz, yd);
         e = exp_q.pop_front();
         total++; if (yd !== e) $display("FAIL random_y a=%h dir=%b mode=%b fill=%b amt=%0d: got %h want %h",
                                         ra, rd, rm, rf, rn, yd, e); else passed++;
         total++; if (lat !== int'(rn) + 1) $display("FAIL random_latency: got %0d want %0d", lat, int'(rn) + 1); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_logic_left;
      test_arith_right;
      test_rotate_left;
      test_fill_right;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
